// File: rtl/sal_ddr2_pkg.sv
// sal_ddr2_pkg
// Shared types and constants for the DDR2 controller read path.
//   rd_cmd_t   : one tracked READ {id, last}
//   rd_beat_t  : one buffered read beat {id, data, last}
//   RRESP_OKAY : AXI response code returned on every read beat
// The struct widths follow the controller's default AXI ID and DFI data widths.
package sal_ddr2_pkg;

    localparam int SAL_ID_WIDTH   = 4;
    localparam int SAL_DATA_WIDTH = 64;

    // DDR2 mode register BL setting; one READ command returns this many beats.
    localparam int SAL_DDR2_BL    = 4;
    localparam int SAL_BURST_LEN  = SAL_DDR2_BL;

    localparam logic [1:0] RRESP_OKAY = 2'b00;

    typedef struct packed {
        logic [SAL_ID_WIDTH-1:0] id;
        logic                    last;
    } rd_cmd_t;

    typedef struct packed {
        logic [SAL_ID_WIDTH-1:0]   id;
        logic [SAL_DATA_WIDTH-1:0] data;
        logic                      last;
    } rd_beat_t;

endpackage

// File: rtl/sal_sync_fifo.sv
// sal_sync_fifo
// Single-clock FIFO with show-ahead read data and an occupancy count.
//   clk, rst  : clock, synchronous active-high reset
//   wr_en     : push wr_data (accepted if not full, or if a pop happens the same cycle)
//   rd_en     : pop the head entry (ignored when empty)
//   rd_data   : current head entry (undefined contents when empty)
//   empty     : no entries stored
//   count     : number of stored entries, 0..DEPTH
module sal_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    import sal_ddr2_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             wr_ok;
    logic             rd_ok;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // A full FIFO still takes a write when the head is popped in the same cycle.
    assign rd_ok = rd_en & ~empty;
    assign wr_ok = wr_en & (~full | rd_ok);

    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            unique case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sal_rd_data_return.sv
// sal_rd_data_return
// DDR2 controller read-data return path. Tracks issued READs in order, tags
// incoming DFI beats with the owning AXI ID / last flag, buffers them and
// returns them on the AXI R channel. rd_cmd_ready is a credit guaranteeing
// every beat of an accepted READ has a buffer slot.
//   clk, rst                          : clock, synchronous active-high reset
//   rd_cmd_valid/id/last, rd_cmd_ready: READ issue from the scheduler
//   dfi_rddata_valid, dfi_rddata      : DFI read beats (no backpressure)
//   axi_r*                            : AXI R channel
//   err_unexp                         : sticky, beat with nothing outstanding or buffer overrun
//   err_timeout                       : sticky watchdog flag
// Build option: SAL_RD_TIMEOUT_EN enables a 16-bit watchdog that flags a READ
// outstanding for 65535 cycles without any DFI beat; otherwise err_timeout is 0.
module sal_rd_data_return
    import sal_ddr2_pkg::*;
#(
    parameter int ID_WIDTH   = SAL_ID_WIDTH,
    parameter int DATA_WIDTH = SAL_DATA_WIDTH,
    parameter int BURST_LEN  = SAL_BURST_LEN,
    parameter int CMD_DEPTH  = 8,
    parameter int DATA_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_cmd_valid,
    input  logic [ID_WIDTH-1:0]   rd_cmd_id,
    input  logic                  rd_cmd_last,
    output logic                  rd_cmd_ready,
    input  logic                  dfi_rddata_valid,
    input  logic [DATA_WIDTH-1:0] dfi_rddata,
    output logic                  axi_rvalid,
    input  logic                  axi_rready,
    output logic [ID_WIDTH-1:0]   axi_rid,
    output logic [DATA_WIDTH-1:0] axi_rdata,
    output logic [1:0]            axi_rresp,
    output logic                  axi_rlast,
    output logic                  err_unexp,
    output logic                  err_timeout
);

    localparam int CMD_W   = ID_WIDTH + 1;
    localparam int BEAT_W  = ID_WIDTH + DATA_WIDTH + 1;
    localparam int CMD_CW  = $clog2(CMD_DEPTH) + 1;
    localparam int DATA_CW = $clog2(DATA_DEPTH) + 1;
    localparam int SUM_W   = DATA_CW + 1;
    localparam int BC_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    logic [CMD_W-1:0]   cmd_head;
    logic               cmd_empty;
    logic [CMD_CW-1:0]  cmd_cnt;
    logic [BEAT_W-1:0]  beat_head;
    logic [BEAT_W-1:0]  beat_in;
    logic               beat_empty;
    logic [DATA_CW-1:0] data_cnt;
    logic [DATA_CW-1:0] pending;
    logic [BC_W-1:0]    beat_cnt;
    logic [SUM_W-1:0]   credit_sum;
    logic               cmd_acc;
    logic               beat_take;
    logic               beat_wrap;
    logic               beat_full;
    logic               r_pop;

    // pending counts beats promised to accepted READs that have not arrived yet,
    // so the credit reserves buffer space for them.
    assign credit_sum   = {1'b0, data_cnt} + {1'b0, pending} + SUM_W'(BURST_LEN);
    assign rd_cmd_ready = (cmd_cnt < CMD_CW'(CMD_DEPTH)) & (credit_sum <= SUM_W'(DATA_DEPTH));
    assign cmd_acc      = rd_cmd_valid & rd_cmd_ready;

    assign beat_take = dfi_rddata_valid & ~cmd_empty;
    assign beat_wrap = (beat_cnt == BC_W'(BURST_LEN - 1));
    assign beat_full = (data_cnt == DATA_CW'(DATA_DEPTH));
    assign beat_in   = {cmd_head[CMD_W-1:1], dfi_rddata, cmd_head[0] & beat_wrap};

    assign r_pop = axi_rvalid & axi_rready;

    sal_sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH), .CNT_W(CMD_CW)) u_cmd_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (cmd_acc),
        .wr_data ({rd_cmd_id, rd_cmd_last}),
        .rd_en   (beat_take & beat_wrap),
        .rd_data (cmd_head),
        .empty   (cmd_empty),
        .count   (cmd_cnt)
    );

    sal_sync_fifo #(.WIDTH(BEAT_W), .DEPTH(DATA_DEPTH), .CNT_W(DATA_CW)) u_beat_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (beat_take),
        .wr_data (beat_in),
        .rd_en   (r_pop),
        .rd_data (beat_head),
        .empty   (beat_empty),
        .count   (data_cnt)
    );

    // Outputs are zeroed while empty so idle/reset values are defined
    // regardless of stale buffer contents.
    assign axi_rvalid = ~beat_empty;
    assign axi_rid    = beat_empty ? '0 : beat_head[BEAT_W-1 -: ID_WIDTH];
    assign axi_rdata  = beat_empty ? '0 : beat_head[DATA_WIDTH:1];
    assign axi_rlast  = ~beat_empty & beat_head[0];
    assign axi_rresp  = RRESP_OKAY;

    always_ff @(posedge clk) begin
        if (rst) begin
            pending   <= '0;
            beat_cnt  <= '0;
            err_unexp <= 1'b0;
        end else begin
            unique case ({cmd_acc, beat_take})
                2'b10:   pending <= pending + DATA_CW'(BURST_LEN);
                2'b01:   pending <= pending - 1'b1;
                2'b11:   pending <= pending + DATA_CW'(BURST_LEN - 1);
                default: pending <= pending;
            endcase
            if (beat_take) begin
                beat_cnt <= beat_wrap ? '0 : beat_cnt + 1'b1;
            end
            if ((dfi_rddata_valid & cmd_empty) | (beat_take & beat_full & ~r_pop)) begin
                err_unexp <= 1'b1;
            end
        end
    end

`ifdef SAL_RD_TIMEOUT_EN
    logic [15:0] wd_cnt;
    logic        err_to_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt   <= '0;
            err_to_q <= 1'b0;
        end else if (dfi_rddata_valid | cmd_empty) begin
            wd_cnt <= '0;
        end else begin
            if (wd_cnt != 16'hFFFF) wd_cnt <= wd_cnt + 1'b1;
            // flag in the same edge the count reaches all-ones
            if (wd_cnt == 16'hFFFE) err_to_q <= 1'b1;
        end
    end

    assign err_timeout = err_to_q;
`else
    assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_sal_rd_data_return.sv
// tb_sal_rd_data_return
// Self-checking bench for sal_rd_data_return: directed scenarios plus a
// randomized phase, all compared against a queue-based reference model.
module tb_sal_rd_data_return;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_cmd_valid;
    logic [3:0]  rd_cmd_id;
    logic        rd_cmd_last;
    logic        rd_cmd_ready;
    logic        dfi_rddata_valid;
    logic [63:0] dfi_rddata;
    logic        axi_rvalid;
    logic        axi_rready;
    logic [3:0]  axi_rid;
    logic [63:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rlast;
    logic        err_unexp;
    logic        err_timeout;

    always #5 clk = ~clk;

    sal_rd_data_return dut (
        .clk              (clk),
        .rst              (rst),
        .rd_cmd_valid     (rd_cmd_valid),
        .rd_cmd_id        (rd_cmd_id),
        .rd_cmd_last      (rd_cmd_last),
        .rd_cmd_ready     (rd_cmd_ready),
        .dfi_rddata_valid (dfi_rddata_valid),
        .dfi_rddata       (dfi_rddata),
        .axi_rvalid       (axi_rvalid),
        .axi_rready       (axi_rready),
        .axi_rid          (axi_rid),
        .axi_rdata        (axi_rdata),
        .axi_rresp        (axi_rresp),
        .axi_rlast        (axi_rlast),
        .err_unexp        (err_unexp),
        .err_timeout      (err_timeout)
    );

    typedef struct {
        logic [3:0] id;
        logic       last;
    } m_cmd_t;

    typedef struct {
        logic [3:0]  id;
        logic [63:0] data;
        logic        last;
    } m_beat_t;

    // Reference model: outstanding READs, buffered beats, beats still owed.
    m_cmd_t  cmdq[$];
    m_beat_t bufq[$];
    int      m_pend;
    int      m_bcnt;
    logic    m_err;
    logic    m_to;
    int      m_wd;

    int n_chk  = 0;
    int n_pass = 0;
    int dut_acc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic bit m_ready();
        return (cmdq.size() < 8) && (bufq.size() + m_pend + 4 <= 16);
    endfunction

    task automatic check_outs();
        bit has;
        has = (bufq.size() != 0);
        chk("rvalid", 64'(axi_rvalid), 64'(has));
        if (has) begin
            chk("rid",   64'(axi_rid),   64'(bufq[0].id));
            chk("rdata", axi_rdata,      bufq[0].data);
            chk("rlast", 64'(axi_rlast), 64'(bufq[0].last));
        end
        chk("rd_cmd_ready", 64'(rd_cmd_ready), 64'(m_ready()));
        chk("err_unexp",    64'(err_unexp),    64'(m_err));
        chk("err_timeout",  64'(err_timeout),  64'(m_to));
        chk("rresp",        64'(axi_rresp),    64'd0);
    endtask

    // One clock: drive inputs, advance model at the edge, check 1 time unit later.
    task automatic cyc(input logic cv, input logic [3:0] cid, input logic cl,
                       input logic dv, input logic [63:0] dd, input logic rr);
        bit      rdy;
        bit      pop;
        bit      wd_clear;
        int      pre_sz;
        m_cmd_t  c;
        m_beat_t b;
        rd_cmd_valid     = cv;
        rd_cmd_id        = cid;
        rd_cmd_last      = cl;
        dfi_rddata_valid = dv;
        dfi_rddata       = dd;
        axi_rready       = rr;
        rdy      = m_ready();
        wd_clear = dv || (cmdq.size() == 0);
        if (cv && rd_cmd_ready) dut_acc++;
        @(posedge clk);
        pre_sz = bufq.size();
        pop    = rr && (pre_sz > 0);
        if (pop) void'(bufq.pop_front());
        if (dv) begin
            if (cmdq.size() == 0) begin
                m_err = 1'b1;
            end else begin
                b.id   = cmdq[0].id;
                b.data = dd;
                b.last = cmdq[0].last && (m_bcnt == 3);
                if (pre_sz == 16 && !pop) m_err = 1'b1;
                else bufq.push_back(b);
                m_pend--;
                m_bcnt++;
                if (m_bcnt == 4) begin
                    m_bcnt = 0;
                    void'(cmdq.pop_front());
                end
            end
        end
        if (cv && rdy) begin
            c.id   = cid;
            c.last = cl;
            cmdq.push_back(c);
            m_pend += 4;
        end
        if (wd_clear) m_wd = 0;
        else m_wd++;
`ifdef SAL_RD_TIMEOUT_EN
        if (m_wd >= 65535) m_to = 1'b1;
`endif
        #1;
        check_outs();
    endtask

    task automatic idle(input int n, input logic rr);
        for (int i = 0; i < n; i++) cyc(1'b0, 4'd0, 1'b0, 1'b0, 64'd0, rr);
    endtask

    task automatic do_reset();
        rst              = 1'b1;
        rd_cmd_valid     = 1'b0;
        rd_cmd_id        = '0;
        rd_cmd_last      = 1'b0;
        dfi_rddata_valid = 1'b0;
        dfi_rddata       = '0;
        axi_rready       = 1'b0;
        @(posedge clk);
        cmdq.delete();
        bufq.delete();
        m_pend = 0;
        m_bcnt = 0;
        m_err  = 1'b0;
        m_to   = 1'b0;
        m_wd   = 0;
        #1;
        chk("rst_rvalid",   64'(axi_rvalid),   64'd0);
        chk("rst_rlast",    64'(axi_rlast),    64'd0);
        chk("rst_rid",      64'(axi_rid),      64'd0);
        chk("rst_rdata",    axi_rdata,         64'd0);
        chk("rst_err_unex", 64'(err_unexp),    64'd0);
        chk("rst_err_to",   64'(err_timeout),  64'd0);
        chk("rst_ready",    64'(rd_cmd_ready), 64'd1);
        rst = 1'b0;
    endtask

    // Feed owed beats with rready high until the model is empty.
    task automatic drain();
        int guard;
        guard = 0;
        while ((m_pend > 0 || bufq.size() > 0) && guard < 200) begin
            cyc(1'b0, 4'd0, 1'b0, m_pend > 0, {$urandom(), $urandom()}, 1'b1);
            guard++;
        end
        chk("drain_done", 64'(guard < 200), 64'd1);
    endtask

    initial begin
        int steps;
        rst = 1'b1;
        do_reset();

        // Single READ, rready high.
        cyc(1'b1, 4'd3, 1'b1, 1'b0, 64'd0, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 4'd0, 1'b0, 1'b1, 64'hD0 + 64'(i), 1'b1);
        idle(2, 1'b1);

        // Two READs of one transaction.
        cyc(1'b1, 4'd1, 1'b0, 1'b0, 64'd0, 1'b1);
        cyc(1'b1, 4'd2, 1'b1, 1'b0, 64'd0, 1'b1);
        for (int i = 0; i < 8; i++) cyc(1'b0, 4'd0, 1'b0, 1'b1, 64'hA000 + 64'(i), 1'b1);
        idle(2, 1'b1);

        // Credit exhaustion with rready low.
        do_reset();
        dut_acc = 0;
        for (int i = 0; i < 6; i++) cyc(1'b1, 4'(i), 1'b1, 1'b0, 64'd0, 1'b0);
        chk("credit_accepts", 64'(dut_acc), 64'd4);
        for (int i = 0; i < 16; i++) cyc(1'b0, 4'd0, 1'b0, 1'b1, 64'hB00 + 64'(i), 1'b0);
        chk("credit_full_rdy", 64'(rd_cmd_ready), 64'd0);
        steps = 0;
        while (!rd_cmd_ready && steps < 20) begin
            cyc(1'b0, 4'd0, 1'b0, 1'b0, 64'd0, 1'b1);
            steps++;
        end
        chk("credit_pops", 64'(steps), 64'd4);
        drain();

        // Unexpected DFI beat.
        cyc(1'b0, 4'd0, 1'b0, 1'b1, 64'hDEAD, 1'b1);
        idle(3, 1'b1);
        chk("unexp_sticky", 64'(err_unexp), 64'd1);

        // Reset in the middle of a burst.
        do_reset();
        cyc(1'b1, 4'd5, 1'b1, 1'b0, 64'd0, 1'b0);
        cyc(1'b0, 4'd0, 1'b0, 1'b1, 64'h11, 1'b0);
        cyc(1'b0, 4'd0, 1'b0, 1'b1, 64'h22, 1'b0);
        do_reset();
        cyc(1'b1, 4'd6, 1'b1, 1'b0, 64'd0, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 4'd0, 1'b0, 1'b1, 64'h6600 + 64'(i), 1'b1);
        idle(2, 1'b1);

        // Randomized traffic, legal DFI timing only.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                (m_pend > 0) && ($urandom_range(0, 1) == 1), {$urandom(), $urandom()},
                ($urandom_range(0, 3) != 0));
        end
        drain();

        // Watchdog: READ outstanding with no beats.
        do_reset();
        cyc(1'b1, 4'd9, 1'b1, 1'b0, 64'd0, 1'b1);
`ifdef SAL_RD_TIMEOUT_EN
        idle(65534, 1'b1);
        chk("to_not_yet", 64'(err_timeout), 64'd0);
        idle(1, 1'b1);
        chk("to_set", 64'(err_timeout), 64'd1);
        idle(3, 1'b1);
`else
        idle(300, 1'b1);
        chk("to_tied_low", 64'(err_timeout), 64'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
